alu_out_stage: RTL
==================

ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning ALU result width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, meaning result buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  ALU result present on in_* this cycle.
REQ-006 SHALL have port in_ready  output  1  buffer accepts a result this cycle.
REQ-007 SHALL have port in_y  input  WIDTH  ALU result y.
REQ-008 SHALL have ports in_cout, in_overflow, in_negative, in_zero  input  1 each  ALU flags.
REQ-009 SHALL have port out_valid  output  1  head entry valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-011 SHALL have port out_y  output  WIDTH  head entry result.
REQ-012 SHALL have port out_flags  output  4  head entry flags {N,Z,C,V}, bit 3 = N.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  entries held.
REQ-014 SHALL have port sticky_flags  output  4  accumulated {N,Z,C,V}.
REQ-015 SHALL have port clr_sticky  input  1  synchronous clear of sticky_flags.

Function
REQ-016 SHALL push when in_valid && in_ready, storing {in_y, in_negative, in_zero, in_cout, in_overflow} in one entry.
REQ-017 SHALL drive in_ready = (count != DEPTH), combinationally from state only, never from in_valid.
REQ-018 SHALL pop when out_valid && out_ready; out_valid = (count != 0).
REQ-019 SHALL present pushed data on out_* no earlier than the cycle after the push (1-cycle latency, no combinational bypass).
REQ-020 SHALL deliver entries in push order, with no loss and no duplication.
REQ-021 SHALL hold out_y and out_flags stable while out_valid && !out_ready.
REQ-022 SHALL on simultaneous push and pop with 0 < count < DEPTH leave count unchanged.
REQ-023 SHALL, when full, refuse the push even if a pop occurs the same cycle; in_ready rises the cycle after the pop.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL ignore out_ready when empty and in_* when in_valid is low.
REQ-026 SHALL on push OR the pushed flags into sticky_flags in the next state.
REQ-027 SHALL when clr_sticky coincides with a push set sticky_flags to exactly the pushed flags (clear before OR).

Reset
REQ-028 SHALL on rst_n low immediately set count=0, out_valid=0, in_ready=1, out_y=0, out_flags=0, sticky_flags=0, with pointers at 0.
REQ-029 SHALL discard all buffered entries when reset asserts mid-operation; the first push after release is the first entry delivered.

Configuration
REQ-030 SHALL compile sticky-flag accumulation only when macro ALU_OUT_STICKY_EN is defined.
REQ-031 SHALL when ALU_OUT_STICKY_EN is undefined keep the sticky_flags and clr_sticky ports, tie sticky_flags to 4'b0000, ignore clr_sticky, and hold no sticky state.

Verification
REQ-032 SHALL cover: reset, push y=4'b0010 with all flags 0 -> next cycle out_valid=1, out_y=4'b0010, out_flags=4'b0000, count=1.
REQ-033 SHALL cover: push 4'b0001, 4'b0011 with out_ready=0 -> count=2, in_ready=0; third push of 4'b0111 refused; pops yield 0001 then 0011.
REQ-034 SHALL cover: full buffer, in_valid=1 and out_ready=1 in the same cycle -> pop only, count=1, in_ready=1 the next cycle.
REQ-035 SHALL cover: with ALU_OUT_STICKY_EN, push flags 4'b1000 then 4'b0001 -> sticky_flags=4'b1001; clr_sticky together with a push of 4'b0100 -> 4'b0100; without the macro -> always 4'b0000.
REQ-036 SHALL cover: count=2 with rst_n pulsed low mid-cycle -> out_valid=0 and count=0 asynchronously; next pushed 4'b1010 is the first output.
REQ-037 SHALL cover: 20 back-to-back pushes with random out_ready, WIDTH=4 and DEPTH=2 -> scoreboard order match and pointer wrap exercised.

Source files
------------

// File: rtl/alu_out_stage.sv
// alu_out_stage: small in-order result buffer between the ALU and its consumer.
// Each entry holds one ALU result word plus its {N,Z,C,V} flags. Results
// appear on out_* one cycle after they are accepted (no bypass path), and the
// buffer refuses new results while full, even when the head is popped in the
// same cycle.
//
// Optional feature: define ALU_OUT_STICKY_EN to build the sticky-flag
// accumulator (OR of every accepted result's flags, cleared by clr_sticky).
// Without it, sticky_flags reads 4'b0000, clr_sticky is ignored and no
// sticky state exists.
module alu_out_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_y,
  input  logic                     in_cout,
  input  logic                     in_overflow,
  input  logic                     in_negative,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               sticky_flags,
  input  logic                     clr_sticky
);

  // Pointer, occupancy and entry widths. DEPTH is a power of two, so a
  // PW-bit pointer covers exactly the entries.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 4;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  // Handshake qualifiers.
  logic          push;
  logic          pop;

  // Entry packing: result in the upper bits, flags {N,Z,C,V} in the low nibble.
  logic [3:0]    in_flags;
  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_entry;

  // Read view of every storage slot.
  logic [EW-1:0] entry_rd [DEPTH];

  // Control state.
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Status flags come purely from the occupancy register so that in_ready
  // never depends on in_valid.
  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

  // A full buffer refuses the push even if the head leaves this cycle; the
  // freed slot becomes visible through in_ready on the following cycle.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign in_flags = {in_negative, in_zero, in_cout, in_overflow};
  assign in_entry = {in_y, in_flags};

  // Storage slots: each slot captures the incoming entry only when it is the
  // current write target. Reset clears the contents so the head reads zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [EW-1:0] entry_reg;

      // Load this slot on an accepted push aimed at it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= in_entry;
        end
      end

      assign entry_rd[gi] = entry_reg;
    end
  endgenerate

  // Head of the buffer. The output is forced to zero while empty so the
  // consumer never sees a stale entry that has already been popped.
  assign head_entry = entry_rd[rd_ptr_reg];
  assign out_y      = out_valid ? head_entry[EW-1:4] : '0;
  assign out_flags  = out_valid ? head_entry[3:0]    : 4'b0000;

  // Next-state for pointers and occupancy; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    end

    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Control state register; reset discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

`ifdef ALU_OUT_STICKY_EN
  logic [3:0] sticky_reg;
  logic [3:0] sticky_next;

  // Clear first, then OR in the accepted flags, so a clear that coincides
  // with a push leaves exactly the pushed flags.
  always_comb begin
    sticky_next = sticky_reg;
    if (clr_sticky) begin
      sticky_next = 4'b0000;
    end
    if (push) begin
      sticky_next = sticky_next | in_flags;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 4'b0000;
    end else begin
      sticky_reg <= sticky_next;
    end
  end

  assign sticky_flags = sticky_reg;
`else
  // Accumulator not built: the port reads zero and the clear has no effect.
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_flags      = 4'b0000;
`endif

endmodule
